// File: rtl/sevenseg_monitor.sv
// Receive-side monitor for the active-low seven-segment countdown bus: debounces
// the pattern, decodes it, tracks its class and flags illegal countdown steps.
module sevenseg_monitor #(
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           segments,
    output logic [3:0]           value,
    output logic                 valid,
    output logic                 blank,
    output logic                 invalid,
    output logic                 upd,
    output logic                 step_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        ST_BLANK   = 2'd0,
        ST_DIGIT   = 2'd1,
        ST_INVALID = 2'd2
    } state_t;

    localparam logic [3:0] STABLE    = 4'(STABLE_CYCLES);
    localparam logic [6:0] ALL_OFF   = 7'b1111111;
    localparam logic [6:0] DIGIT_CODES [11] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
        7'b0001000
    };

    state_t                state_reg, state_next;
    logic [6:0]            cand_reg, acc_reg;
    logic [3:0]            cnt_reg;
    logic [3:0]            value_reg;
    logic                  upd_reg, step_err_reg;
    logic [ERR_CNT_W-1:0]  err_count_reg;

    logic [10:0]           hit;
    logic [3:0]            dec_value;
    state_t                dec_class;
    logic                  accept;
    logic                  step_illegal;

    genvar gi;
    generate
        for (gi = 0; gi < 11; gi++) begin : g_dec
            assign hit[gi] = (cand_reg == DIGIT_CODES[gi]);
        end
    endgenerate

    always_comb begin
        dec_value = 4'd0;
        dec_class = (cand_reg == ALL_OFF) ? ST_BLANK : ST_INVALID;
        for (int i = 0; i < 11; i++) begin
            if (hit[i]) begin
                dec_value = 4'(i);
                dec_class = ST_DIGIT;
            end
        end
    end

    // A candidate is accepted only once it has been held long enough and differs from acc.
    assign accept = (cnt_reg == STABLE) && (cand_reg != acc_reg);

    always_comb begin
        step_illegal = 1'b0;
        if (accept && dec_class == ST_DIGIT) begin
            case (state_reg)
                ST_DIGIT:   step_illegal = (value_reg == 4'd0) || (dec_value != value_reg - 4'd1);
                ST_INVALID: step_illegal = 1'b1;
                default:    step_illegal = 1'b0;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state_reg <= ST_BLANK;
        else      state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        if (accept) state_next = dec_class;
    end

    // Output logic
    always_comb begin
        valid   = (state_reg == ST_DIGIT);
        blank   = (state_reg == ST_BLANK);
        invalid = (state_reg == ST_INVALID);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cand_reg      <= ALL_OFF;
            cnt_reg       <= 4'd0;
            acc_reg       <= ALL_OFF;
            value_reg     <= 4'd0;
            upd_reg       <= 1'b0;
            step_err_reg  <= 1'b0;
            err_count_reg <= '0;
        end else begin
            if (segments != cand_reg) begin
                cand_reg <= segments;
                cnt_reg  <= 4'd1;
            end else if (cnt_reg < STABLE) begin
                cnt_reg  <= cnt_reg + 4'd1;
            end
            upd_reg      <= accept;
            step_err_reg <= step_illegal;
            if (accept) begin
                acc_reg <= cand_reg;
                if (dec_class == ST_DIGIT) value_reg <= dec_value;
            end
            if (step_illegal && (err_count_reg != {ERR_CNT_W{1'b1}}))
                err_count_reg <= err_count_reg + 1'b1;
        end
    end

    assign value     = value_reg;
    assign upd       = upd_reg;
    assign step_err  = step_err_reg;
    assign err_count = err_count_reg;

endmodule

// File: doc/sevenseg_monitor.md
Name: sevenseg_monitor

Overview:
- Receive-side checker for the countdown seven-segment bus: samples the 7-bit active-low segment pattern driven by the display controller, filters glitches, decodes it back to a 4-bit value and classifies it as digit, blank or invalid.
- Checks that successive displayed digits form a legal countdown and counts violations.
- Sits on the game board next to the display driver as a self-check / loopback monitor; its outputs feed LEDs and the game FSM's fault input.

Parameters:
- STABLE_CYCLES, 4, number of consecutive cycles a pattern must be held before acceptance; legal range 1..15.
- ERR_CNT_W, 8, width of the saturating violation counter.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-low reset (rst=0 resets on the next clk edge)
- segments  input  7  pattern {g,f,e,d,c,b,a}; bit=0 means segment lit
- value  output  4  last accepted digit value (0..10)
- valid  output  1  1 while the accepted pattern is a digit
- blank  output  1  1 while the accepted pattern is all-off (7'b1111111)
- invalid  output  1  1 while the accepted pattern matches no table entry
- upd  output  1  one-cycle pulse on every acceptance of a new pattern
- step_err  output  1  one-cycle pulse, coincident with upd, on an illegal countdown step
- err_count  output  ERR_CNT_W  saturating count of step_err pulses

Behaviour:
- Decode table (segments -> value):
  - 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4
  - 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9, 0001000->10
  - 1111111 -> blank; any other code -> invalid.
- Stability filter: registers cand[6:0] and cnt[3:0].
  - Each edge: if segments != cand then cand<=segments and cnt<=1.
  - Otherwise, if cnt<STABLE_CYCLES then cnt<=cnt+1; cnt saturates at STABLE_CYCLES.
- Acceptance: on an edge where cnt==STABLE_CYCLES and cand != acc (the accepted pattern):
  - acc<=cand;
  - state/outputs update;
  - upd=1 for exactly that cycle.
- Latency: a new pattern held from edge 1 onward is accepted and visible on outputs after edge STABLE_CYCLES+1.
- Glitch rejection: any pattern held fewer than STABLE_CYCLES+1 edges is never accepted and produces no upd. Returning to the current acc pattern also produces no upd.
- FSM states, tracking the class of acc:
  - ST_BLANK (blank=1)
  - ST_DIGIT (valid=1)
  - ST_INVALID (invalid=1)
  - Exactly one of blank/valid/invalid is high at all times.
  - Transitions occur only on acceptance, to the class of the new acc; any state can reach any state.
- value is loaded only when a digit is accepted. It holds its last digit through ST_BLANK and ST_INVALID.
- Countdown rule, evaluated only on acceptance of a digit d:
  - Previous state ST_DIGIT with old value v: legal iff d==v-1. v==0 followed by any digit is illegal.
  - Previous state ST_BLANK: any d is legal (reload).
  - Previous state ST_INVALID: illegal.
  - Accepting blank or invalid never raises step_err.
  - Illegal -> step_err=1 for that cycle, and err_count increments unless it equals 2^ERR_CNT_W-1 (saturate, no wrap).
- Reset (rst=0 at an edge), applies mid-operation as well:
  - cand<=7'b1111111, acc<=7'b1111111, cnt<=0, state<=ST_BLANK;
  - value=0, valid=0, blank=1, invalid=0, upd=0, step_err=0, err_count=0.
  - Reset dominates acceptance on the same edge.
  - After release, an all-off input causes no upd.
- Simultaneous events: an input change on the acceptance edge is handled as follows:
  - acceptance of the old cand completes;
  - cand<=new pattern with cnt<=1;
  - the new pattern follows the normal latency.

Test Plan:
- Reset, then hold 0010010 ("5") with STABLE_CYCLES=4 -> upd pulses after 5th edge; value=5, valid=1, blank=0, step_err=0.
- From accepted 5: hold "4", then "3" (each 10 cycles) -> two upd pulses; value 4 then 3; err_count stays 0.
- From accepted 3: inject "7" for 3 cycles, then return to "3" -> no upd; value stays 3.
- From accepted 3: hold "6" -> upd with step_err=1; err_count=1. Then blank, then "9" -> blank=1, then valid with value=9 and no step_err.
- Hold 0101010 (undefined) -> invalid=1, value unchanged. Then "2" -> step_err=1.
- Force err_count to 255 via repeated illegal steps; one more illegal step -> step_err pulses, err_count stays 255. Assert rst=0 mid-settle -> all outputs at reset values on the next edge.
